uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while run is high, pulses bit_tick on the last count.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign bit_tick = run && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to add the parity_odd input and the PARITY state.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 txd_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 accept;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_next;
`endif

    // Handshake: a byte moves when tx_valid and tx_ready are both high at a
    // rising edge; tx_ready is high only in IDLE, so inputs are ignored mid-frame.
    assign tx_ready = (state == IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .run      (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_bit;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    shreg_next = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^tx_data) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                        stop_cnt_next = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is registered from the next state so txd changes on the same
    // edge as the state it belongs to.
    always_comb begin
        txd_next  = LINE_IDLE;
        busy_next = (state_next != IDLE);
        case (state_next)
            IDLE:   txd_next = LINE_IDLE;
            START:  txd_next = LINE_START;
            DATA:   txd_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_next = parity_next;
`else
            PARITY: txd_next = LINE_IDLE;
`endif
            STOP:   txd_next = LINE_IDLE;
            default: txd_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= LINE_IDLE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            txd      <= txd_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bit <= 1'b0;
        end else begin
            parity_bit <= parity_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl against a per-cycle line-waveform reference model.
module tb_uart_tx_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int STOP_BITS = 2;
    localparam int PAR_BITS  = 1;
`else
    localparam int STOP_BITS = 1;
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_CYC = (1 + DATA_BITS + PAR_BITS + STOP_BITS) * CLK_DIV;

    logic                 clk;
    logic                 reset;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 parity_odd;
    logic                 tx_ready;
    logic                 txd;
    logic                 tx_busy;
    logic                 tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    // expected line level for each upcoming cycle of the current frame
    logic [0:0] exp_q[$];
    logic       exp_done;
    int         cyc;
    int         busy_run;
    int         last_done_cyc;
    logic       gap_en;
    logic       gap_seen;

    uart_tx_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx_ready   (tx_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model: an accepted byte expands into its full per-cycle waveform
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            logic par;
            cyc++;
            exp_done = 1'b0;
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end else if (tx_valid) begin
                par = (^tx_data) ^ parity_odd;
                for (int i = 0; i < CLK_DIV; i++) exp_q.push_back(1'b0);
                for (int b = 0; b < DATA_BITS; b++)
                    for (int i = 0; i < CLK_DIV; i++) exp_q.push_back(tx_data[b]);
                for (int i = 0; i < PAR_BITS * CLK_DIV; i++) exp_q.push_back(par);
                for (int i = 0; i < STOP_BITS * CLK_DIV; i++) exp_q.push_back(1'b1);
            end
        end
    end

    // scoreboard: every cycle, compare line and status against the model
    always @(negedge clk) begin
        logic exp_txd;
        exp_txd = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
        check("txd", txd, exp_txd);
        check("tx_busy", tx_busy, exp_q.size() != 0);
        check("tx_ready", tx_ready, exp_q.size() == 0);
        check("tx_done", tx_done, exp_done);
        if (!reset) begin
            busy_run = 0;
        end else if (tx_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            check("frame_len", busy_run, FRAME_CYC);
            busy_run = 0;
        end
        if (tx_done) begin
            if (gap_en && last_done_cyc >= 0) begin
                check("b2b_gap", cyc - last_done_cyc, FRAME_CYC + 1);
                gap_seen = 1'b1;
            end
            last_done_cyc = cyc;
        end
    end

    // driver tasks
    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic send(input logic [DATA_BITS-1:0] d, input logic p);
        wait_idle();
        tx_data    = d;
        parity_odd = p;
        tx_valid   = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
    endtask

    initial begin
        cyc           = 0;
        busy_run      = 0;
        last_done_cyc = -1;
        gap_en        = 1'b0;
        gap_seen      = 1'b0;
        reset         = 1'b0;
        tx_valid      = 1'b1;
        tx_data       = DATA_BITS'($urandom);
        parity_odd    = 1'b0;

        // reset held with tx_valid high: nothing may be accepted
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_ready", tx_ready, 1'b1);

        // first frame: A5 accepted on the first edge after release
        tx_data = 8'hA5;
        reset   = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;

        // back-to-back 00 then FF with tx_valid held
        wait_idle();
        gap_en        = 1'b1;
        last_done_cyc = -1;
        tx_data       = 8'h00;
        tx_valid      = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 200 && !exp_done; i++) @(negedge clk);
        check("b2b_done_timeout", exp_done, 1'b1);
        tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("b2b_seen", gap_seen, 1'b1);
        gap_en = 1'b0;

        // data changes mid-frame are ignored
        send(8'hC3, 1'b0);
        repeat (10) @(negedge clk);
        tx_data = 8'h3C;
        repeat (10) @(negedge clk);
        tx_data = 8'h5A;

        // reset during data bit 3 (low bits of F0 keep the line low there)
        send(8'hF0, 1'b0);
        repeat (16) @(negedge clk);
        check("pre_rst_txd", txd, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(8'h96, 1'b0);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0);
        send(8'h07, 1'b1);
`endif

        // random frames with random idle gaps, some back-to-back
        for (int n = 0; n < 24; n++) begin
            send(DATA_BITS'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
